// File: rtl/uart_reg_bridge_pkg.sv
// Shared opcodes, FSM state encoding and helpers for the UART register bridge.
package uart_reg_bridge_pkg;

    localparam logic [7:0] OP_WR = 8'h57;
    localparam logic [7:0] OP_RD = 8'h52;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        GET_ADDR = 3'd1,
        GET_DATA = 3'd2,
        BUS      = 3'd3,
        SEND_ACK = 3'd4,
        SEND_RD  = 3'd5,
        SEND_NAK = 3'd6,
        SEND_ERR = 3'd7
    } state_t;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/uart_reg_bridge_if.sv
// UART FIFO pins plus single-master register bus, seen from the bridge (master)
// and from the UART/register side (slave).
interface uart_reg_bridge_if;
    logic       rxempty;
    logic [7:0] rdata;
    logic       rduart;
    logic       txfull;
    logic       wruart;
    logic [7:0] wdata;
    logic       reg_req;
    logic       reg_we;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_ack;
    logic [7:0] reg_rdata;

    modport master (
        input  rxempty, rdata, txfull, reg_ack, reg_rdata,
        output rduart, wruart, wdata, reg_req, reg_we, reg_addr, reg_wdata
    );

    modport slave (
        output rxempty, rdata, txfull, reg_ack, reg_rdata,
        input  rduart, wruart, wdata, reg_req, reg_we, reg_addr, reg_wdata
    );
endinterface

// File: rtl/bridge_timeout.sv
// Cycle counter that raises expired once LIMIT-1 enabled cycles follow a clear.
// Latency: expired is a registered-count compare, valid the cycle the count lands.
// Backpressure: none; holds at LIMIT-1 until cleared.
module bridge_timeout #(
    parameter int LIMIT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int W = $clog2(LIMIT);

    logic [W-1:0] cnt_q, cnt_d;

    assign expired = (cnt_q == W'(LIMIT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && !expired) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/uart_reg_bridge.sv
// Byte-protocol bridge: RX FIFO commands become register bus accesses, replies go to TX FIFO.
// Latency: reg_req the cycle after the last operand pop; reply push the cycle after ack/timeout.
// Backpressure: waits on rxempty without popping; holds the reply state while txfull.
module uart_reg_bridge
    import uart_reg_bridge_pkg::*;
#(
    parameter int         TIMEOUT_CYC = 1024,
    parameter logic [7:0] ACK_BYTE    = 8'h06,
    parameter logic [7:0] NAK_BYTE    = 8'h15,
    parameter logic [7:0] ERR_BYTE    = 8'h3F
) (
    input  logic               clk,
    input  logic               rst,
    uart_reg_bridge_if.master  bus,
    output logic               busy,
    output logic [7:0]         err_cnt
);
    state_t     state_q, state_d;
    logic       is_wr_q, is_wr_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] wdat_q, wdat_d;
    logic [7:0] rd_q, rd_d;
    logic [7:0] tx_byte_q, tx_byte_d;
    logic [7:0] err_q, err_d;
    logic       pop, push, in_bus, expired;

    assign in_bus = (state_q == BUS);
    // Strobes are suppressed during reset so a stale state can never move a FIFO.
    assign pop  = !rst && !bus.rxempty && (state_q inside {IDLE, GET_ADDR, GET_DATA});
    assign push = !rst && !bus.txfull  && (state_q inside {SEND_ACK, SEND_RD, SEND_NAK, SEND_ERR});

    bridge_timeout #(.LIMIT(TIMEOUT_CYC)) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clr     (!in_bus),
        .en      (in_bus && !bus.reg_ack),
        .expired (expired)
    );

    always_comb begin
        state_d   = state_q;
        is_wr_d   = is_wr_q;
        addr_d    = addr_q;
        wdat_d    = wdat_q;
        rd_d      = rd_q;
        tx_byte_d = tx_byte_q;
        err_d     = err_q;
        case (state_q)
            IDLE: if (pop) begin
                if (bus.rdata == OP_WR || bus.rdata == OP_RD) begin
                    is_wr_d = (bus.rdata == OP_WR);
                    state_d = GET_ADDR;
                end else begin
                    tx_byte_d = ERR_BYTE;
                    err_d     = sat_inc(err_q);
                    state_d   = SEND_ERR;
                end
            end
            GET_ADDR: if (pop) begin
                addr_d  = bus.rdata;
                state_d = is_wr_q ? GET_DATA : BUS;
            end
            GET_DATA: if (pop) begin
                wdat_d  = bus.rdata;
                state_d = BUS;
            end
            BUS: if (bus.reg_ack) begin
                rd_d      = bus.reg_rdata;
                tx_byte_d = ACK_BYTE;
                state_d   = SEND_ACK;
            end else if (expired) begin
                tx_byte_d = NAK_BYTE;
                err_d     = sat_inc(err_q);
                state_d   = SEND_NAK;
            end
            SEND_ACK: if (push) begin
                tx_byte_d = rd_q;
                state_d   = is_wr_q ? IDLE : SEND_RD;
            end
            SEND_RD, SEND_NAK, SEND_ERR: if (push) begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            is_wr_q   <= 1'b0;
            addr_q    <= '0;
            wdat_q    <= '0;
            rd_q      <= '0;
            tx_byte_q <= '0;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            is_wr_q   <= is_wr_d;
            addr_q    <= addr_d;
            wdat_q    <= wdat_d;
            rd_q      <= rd_d;
            tx_byte_q <= tx_byte_d;
            err_q     <= err_d;
        end
    end

    assign bus.rduart    = pop;
    assign bus.wruart    = push;
    assign bus.wdata     = tx_byte_q;
    assign bus.reg_req   = in_bus;
    assign bus.reg_we    = is_wr_q;
    assign bus.reg_addr  = addr_q;
    assign bus.reg_wdata = wdat_q;
    assign busy          = (state_q != IDLE);
    assign err_cnt       = err_q;
endmodule

// File: tb/tb_uart_reg_bridge.sv
// Bench for uart_reg_bridge: emulated RX/TX FIFOs and register slave, packet-level
// reply model, and a per-cycle monitor comparing the DUT against that model.
module tb_uart_reg_bridge;
    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       busy;
    logic [7:0] err_cnt;

    uart_reg_bridge_if u_if ();

    uart_reg_bridge #(.TIMEOUT_CYC(TO)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (u_if),
        .busy    (busy),
        .err_cnt (err_cnt)
    );

    always #5 clk = ~clk;

    int nvec  = 0;
    int nfail = 0;

    // Environment and model state
    logic [7:0] rx_q[$];
    logic [7:0] tx_log[$];
    int         tx_cyc[$];
    logic [7:0] exp_b[$];
    bit         exp_e[$];
    int         model_err = 0;
    bit         cur_op_vld = 0;
    bit         cur_we;
    logic [7:0] cur_addr, cur_wd;
    int         exp_req_len = 0;
    int         ack_on = 0;
    logic [7:0] slave_rd = 8'h00;
    bit         stray_ack = 0;
    bit         pop_pend = 0;
    int         drv_run = 0;
    int         cyc = 0;
    int         req_run = 0;
    bit         was_req = 0;
    int         last_req_len = 0;
    int         ack_cyc = 0;
    logic [7:0] last_addr, last_wd;
    bit         last_we;

    function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endfunction

    task automatic cycle_wait(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Packet-level model: what the bus should see and which bytes must come back.
    task automatic expect_pkt(input logic [7:0] op, input logic [7:0] a, input logic [7:0] d,
                              input int ack_at, input logic [7:0] rd);
        bit ok;
        ok       = (ack_at >= 1) && (ack_at <= TO);
        ack_on   = ack_at;
        slave_rd = rd;
        if (op == 8'h57 || op == 8'h52) begin
            cur_op_vld  = 1;
            cur_we      = (op == 8'h57);
            cur_addr    = a;
            cur_wd      = d;
            exp_req_len = ok ? ack_at : TO;
            if (!ok) begin
                exp_b.push_back(8'h15); exp_e.push_back(1'b1);
            end else begin
                exp_b.push_back(8'h06); exp_e.push_back(1'b0);
                if (op == 8'h52) begin
                    exp_b.push_back(rd); exp_e.push_back(1'b0);
                end
            end
        end else begin
            exp_b.push_back(8'h3F); exp_e.push_back(1'b1);
        end
    endtask

    task automatic wait_done(input string name, input int budget);
        int n;
        n = 0;
        while ((rx_q.size() != 0 || exp_b.size() != 0 || busy) && n < budget) begin
            cycle_wait(1);
            n++;
        end
        chk(name, 32'(n < budget), 32'd1);
        cycle_wait(2);
    endtask

    // FIFO emulation and register slave, updated just after each rising edge.
    initial begin
        u_if.rxempty   = 1'b1;
        u_if.rdata     = 8'h00;
        u_if.txfull    = 1'b0;
        u_if.reg_ack   = 1'b0;
        u_if.reg_rdata = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            if (pop_pend && rx_q.size() > 0) void'(rx_q.pop_front());
            pop_pend = 0;
            u_if.rxempty = (rx_q.size() == 0);
            u_if.rdata   = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
            if (u_if.reg_req) begin
                drv_run++;
                u_if.reg_ack = (drv_run == ack_on);
            end else begin
                drv_run = 0;
                u_if.reg_ack = stray_ack;
            end
            u_if.reg_rdata = (u_if.reg_ack && u_if.reg_req) ? slave_rd : ~slave_rd;
        end
    end

    // Per-cycle compare against the model, sampled mid-cycle.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            chk("no_strobe_in_reset", 32'({u_if.rduart, u_if.wruart}), 32'd0);
            was_req  = 0;
            req_run  = 0;
            pop_pend = 0;
        end else begin
            chk("strobes_exclusive", 32'(u_if.rduart && u_if.wruart), 32'd0);
            pop_pend = u_if.rduart;
            if (u_if.rduart) chk("pop_only_when_nonempty", 32'(u_if.rxempty), 32'd0);
            if (u_if.wruart) begin
                chk("push_only_when_not_full", 32'(u_if.txfull), 32'd0);
                tx_log.push_back(u_if.wdata);
                tx_cyc.push_back(cyc);
                chk("push_was_expected", 32'(exp_b.size() != 0), 32'd1);
                if (exp_b.size() != 0) begin
                    chk("tx_byte", 32'(u_if.wdata), 32'(exp_b[0]));
                    if (exp_e[0]) begin
                        model_err = (model_err >= 255) ? 255 : model_err + 1;
                        chk("err_cnt_at_error_reply", 32'(err_cnt), 32'(model_err));
                    end
                    void'(exp_b.pop_front());
                    void'(exp_e.pop_front());
                end
            end
            if (u_if.reg_req) begin
                chk("req_expected", 32'(cur_op_vld), 32'd1);
                if (cur_op_vld) begin
                    chk("reg_we", 32'(u_if.reg_we), 32'(cur_we));
                    chk("reg_addr", 32'(u_if.reg_addr), 32'(cur_addr));
                    if (cur_we) chk("reg_wdata", 32'(u_if.reg_wdata), 32'(cur_wd));
                end
                last_addr = u_if.reg_addr;
                last_we   = u_if.reg_we;
                last_wd   = u_if.reg_wdata;
                req_run++;
                if (u_if.reg_ack) ack_cyc = cyc;
                was_req = 1;
            end else if (was_req) begin
                chk("req_len", 32'(req_run), 32'(exp_req_len));
                last_req_len = req_run;
                req_run      = 0;
                was_req      = 0;
                cur_op_vld   = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n0;
        rst = 1'b1;
        cycle_wait(3);
        chk("rst_reg_req", 32'(u_if.reg_req), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
        chk("rst_wruart", 32'(u_if.wruart), 32'd0);
        chk("rst_wdata", 32'(u_if.wdata), 32'd0);
        chk("rst_rduart", 32'(u_if.rduart), 32'd0);
        rst = 1'b0;
        cycle_wait(2);

        // Stray acks while idle must be ignored.
        stray_ack = 1;
        cycle_wait(5);
        chk("stray_ack_busy", 32'(busy), 32'd0);
        stray_ack = 0;
        cycle_wait(1);

        // Write 57 10 A5, ack on 3rd request cycle.
        expect_pkt(8'h57, 8'h10, 8'hA5, 3, 8'h00);
        rx_q.push_back(8'h57); rx_q.push_back(8'h10); rx_q.push_back(8'hA5);
        wait_done("write_done", 200);
        chk("write_req_len", 32'(last_req_len), 32'd3);
        chk("write_addr", 32'(last_addr), 32'h10);
        chk("write_we", 32'(last_we), 32'd1);
        chk("write_wdata", 32'(last_wd), 32'hA5);
        chk("write_reply", 32'(tx_log[tx_log.size()-1]), 32'h06);
        chk("write_busy_fell", 32'(busy), 32'd0);

        // Ack on the final allowed cycle beats the timeout.
        expect_pkt(8'h57, 8'h44, 8'h5A, TO, 8'h00);
        rx_q.push_back(8'h57); rx_q.push_back(8'h44); rx_q.push_back(8'h5A);
        wait_done("ack_at_limit_done", 200);
        chk("ack_at_limit_len", 32'(last_req_len), 32'd16);
        chk("ack_at_limit_reply", 32'(tx_log[tx_log.size()-1]), 32'h06);
        chk("ack_at_limit_err", 32'(err_cnt), 32'd0);

        // Read 52 22 returning 3C: 06 then 3C at ack+1 and ack+2.
        n0 = tx_log.size();
        expect_pkt(8'h52, 8'h22, 8'h00, 2, 8'h3C);
        rx_q.push_back(8'h52); rx_q.push_back(8'h22);
        wait_done("read_done", 200);
        chk("read_count", 32'(tx_log.size() - n0), 32'd2);
        if (tx_log.size() - n0 == 2) begin
            chk("read_byte0", 32'(tx_log[n0]), 32'h06);
            chk("read_byte1", 32'(tx_log[n0+1]), 32'h3C);
            chk("read_ack_latency", 32'(tx_cyc[n0] - ack_cyc), 32'd1);
            chk("read_data_latency", 32'(tx_cyc[n0+1] - ack_cyc), 32'd2);
        end
        chk("read_we", 32'(last_we), 32'd0);

        // Read with immediate ack.
        expect_pkt(8'h52, 8'h7F, 8'h00, 1, 8'hC3);
        rx_q.push_back(8'h52); rx_q.push_back(8'h7F);
        wait_done("read_fast_done", 200);
        chk("read_fast_len", 32'(last_req_len), 32'd1);
        chk("read_fast_data", 32'(tx_log[tx_log.size()-1]), 32'hC3);

        // Timeout: 52 01, no ack.
        expect_pkt(8'h52, 8'h01, 8'h00, 0, 8'h00);
        rx_q.push_back(8'h52); rx_q.push_back(8'h01);
        wait_done("timeout_done", 200);
        chk("timeout_req_len", 32'(last_req_len), 32'd16);
        chk("timeout_reply", 32'(tx_log[tx_log.size()-1]), 32'h15);
        chk("timeout_err_cnt", 32'(err_cnt), 32'd1);

        // Bad opcode under TX backpressure.
        u_if.txfull = 1'b1;
        n0 = tx_log.size();
        expect_pkt(8'h41, 8'h00, 8'h00, 0, 8'h00);
        rx_q.push_back(8'h41);
        cycle_wait(20);
        chk("bp_no_push", 32'(tx_log.size() - n0), 32'd0);
        chk("bp_busy", 32'(busy), 32'd1);
        u_if.txfull = 1'b0;
        wait_done("bp_done", 100);
        chk("bp_one_push", 32'(tx_log.size() - n0), 32'd1);
        chk("bp_reply", 32'(tx_log[tx_log.size()-1]), 32'h3F);
        chk("bp_err_cnt", 32'(err_cnt), 32'd2);

        // Starved RX: data byte arrives 50 cycles late.
        expect_pkt(8'h57, 8'h10, 8'hA5, 2, 8'h00);
        rx_q.push_back(8'h57); rx_q.push_back(8'h10);
        for (int i = 0; i < 50; i++) begin
            cycle_wait(1);
            chk("starved_no_req", 32'(u_if.reg_req), 32'd0);
        end
        chk("starved_busy", 32'(busy), 32'd1);
        rx_q.push_back(8'hA5);
        wait_done("starved_done", 200);
        chk("starved_wdata", 32'(last_wd), 32'hA5);
        chk("starved_reply", 32'(tx_log[tx_log.size()-1]), 32'h06);

        // Reset while the bus request is outstanding.
        expect_pkt(8'h52, 8'h05, 8'h00, 0, 8'h00);
        rx_q.push_back(8'h52); rx_q.push_back(8'h05);
        for (int i = 0; i < 50 && !u_if.reg_req; i++) cycle_wait(1);
        chk("reset_reached_bus", 32'(u_if.reg_req), 32'd1);
        cycle_wait(3);
        n0 = tx_log.size();
        rst = 1'b1;
        cycle_wait(1);
        chk("reset_drops_req", 32'(u_if.reg_req), 32'd0);
        chk("reset_clears_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        exp_b.delete();
        exp_e.delete();
        cur_op_vld = 0;
        model_err  = 0;
        cycle_wait(20);
        chk("reset_no_reply", 32'(tx_log.size() - n0), 32'd0);
        chk("reset_err_cnt", 32'(err_cnt), 32'd0);

        expect_pkt(8'h57, 8'h33, 8'h77, 1, 8'h00);
        rx_q.push_back(8'h57); rx_q.push_back(8'h33); rx_q.push_back(8'h77);
        wait_done("post_reset_done", 200);
        chk("post_reset_addr", 32'(last_addr), 32'h33);
        chk("post_reset_reply", 32'(tx_log[tx_log.size()-1]), 32'h06);

        // err_cnt saturation with a long burst of bad opcodes.
        for (int i = 0; i < 260; i++) begin
            expect_pkt((i % 2 == 1) ? 8'h00 : 8'hA0, 8'h00, 8'h00, 0, 8'h00);
            rx_q.push_back((i % 2 == 1) ? 8'h00 : 8'hA0);
        end
        wait_done("saturate_done", 2000);
        chk("err_cnt_saturated", 32'(err_cnt), 32'hFF);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
